fp_mul_arbiter: RTL

- Round-robin arbiter that shares one IEEE754 single-precision multiplier (ready/op1/op2 in, res/done out) among N requesters.
- Captures one requester's operand pair and pulses the multiplier start.
- Waits for the multiplier's done pulse, then returns the result to the granted requester.
- Sits between the requesting FSMs and the multiplier instance; only one operation is in flight at a time.

---
 rtl/fp_mul_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier among N requesters.
// Optional watchdog on the multiplier wait: define FPMA_TIMEOUT_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no operation in flight; pick next requester round-robin
//   ISSUE   | pulse mul_ready and req_ack for the captured requester
//   WAIT    | operands held stable until mul_done (or watchdog expiry)
//   RESP    | pulse resp_valid to the granted requester
module fp_mul_arbiter #(
   parameter int N       = 4,
   parameter int IDW     = $clog2(N),
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   input  logic [32*N-1:0]   req_op1,
   input  logic [32*N-1:0]   req_op2,
   output logic [N-1:0]      req_ack,
   output logic [N-1:0]      resp_valid,
   output logic [31:0]       resp_res,
   output logic              resp_err,
   output logic              busy,
   output logic [IDW-1:0]    gnt_id,
   output logic              mul_ready,
   output logic [31:0]       mul_op1,
   output logic [31:0]       mul_op2,
   input  logic [31:0]       mul_res,
   input  logic              mul_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] gnt_q, gnt_d;
   logic [31:0]    op1_q, op1_d;
   logic [31:0]    op2_q, op2_d;
   logic [31:0]    res_q, res_d;

   logic [31:0]    op1_arr [N];
   logic [31:0]    op2_arr [N];
   logic           pick_found;
   logic [IDW-1:0] pick_id;
   logic [IDW-1:0] cand;

`ifdef FPMA_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
`endif

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign op1_arr[g] = req_op1[32*g +: 32];
      assign op2_arr[g] = req_op2[32*g +: 32];
   end

   // First requester after the last granted one, wrapping modulo N.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = last_q;
      cand       = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDW'((int'(last_q) + k) % N);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      res_d   = res_q;
`ifdef FPMA_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               gnt_d   = pick_id;
               op1_d   = op1_arr[pick_id];
               op2_d   = op2_arr[pick_id];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            last_d  = gnt_q;
            state_d = S_WAIT;
`ifdef FPMA_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (mul_done) begin
               res_d   = mul_res;
               state_d = S_RESP;
`ifdef FPMA_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
`ifdef FPMA_TIMEOUT_EN
            // TIMEOUT-th WAIT cycle without done: answer with a quiet NaN.
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_d   = 32'h7FC0_0000;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         last_q  <= IDW'(N - 1);
         gnt_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         res_q   <= '0;
`ifdef FPMA_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         res_q   <= res_d;
`ifdef FPMA_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign mul_ready  = (state_q == S_ISSUE);
   assign req_ack    = (state_q == S_ISSUE) ? (N'(1) << gnt_q) : '0;
   assign resp_valid = (state_q == S_RESP)  ? (N'(1) << gnt_q) : '0;
   assign resp_res   = res_q;
   assign gnt_id     = gnt_q;
   assign mul_op1    = op1_q;
   assign mul_op2    = op2_q;
`ifdef FPMA_TIMEOUT_EN
   assign resp_err   = (state_q == S_RESP) && err_q;
`else
   assign resp_err   = 1'b0;
`endif

endmodule
